block_dec: RTL and testbench

BLOCK_DEC -- requirements
Module: block_dec

---
 rtl/block_dec_pkg.sv | 33 +++
 rtl/block_dec_if.sv | 25 ++
 rtl/block_dec_dec_round.sv | 21 ++
 rtl/block_dec.sv | 119 +++++++++++
 tb/tb_block_dec.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_dec_pkg.sv
// Shared definitions for the block cipher pair (ENC / block_dec).
// Holds the FSM state encoding, default round count, rotate amount,
// the latched block payload type and the round-key derivation function.
package block_dec_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned KEY_W          = 8;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned BLK_CNT_W      = 16;
    localparam int unsigned ROUNDS_DEFAULT = 4;
    localparam int unsigned ROT_AMT        = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Block latched at acceptance: working data word and key.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEY_W-1:0]  key;
    } blk_t;

    // Round key k_r = rotl8(K, r).
    function automatic logic [KEY_W-1:0] round_key(input logic [KEY_W-1:0] k,
                                                   input logic [CNT_W-1:0] r);
        logic [2*KEY_W-1:0] t;
        t = {k, k} << r;
        return t[2*KEY_W-1:KEY_W];
    endfunction

endpackage

// File: rtl/block_dec_if.sv
// Handshake bus for block_dec.
// Input side:  D_IN, K_IN, IN_VALID (to block), IN_READY (from block).
// Output side: D_OUT, OUT_VALID (from block), OUT_READY (to block).
// slave modport is the block's view, master is the driver/consumer view.
interface block_dec_if;
    import block_dec_pkg::*;

    logic [DATA_W-1:0] D_IN;
    logic [KEY_W-1:0]  K_IN;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] D_OUT;
    logic              OUT_VALID;
    logic              OUT_READY;

    modport slave (
        input  D_IN, K_IN, IN_VALID, OUT_READY,
        output IN_READY, D_OUT, OUT_VALID
    );

    modport master (
        output D_IN, K_IN, IN_VALID, OUT_READY,
        input  IN_READY, D_OUT, OUT_VALID
    );
endinterface

// File: rtl/block_dec_dec_round.sv
// dec_round: one combinational inverse cipher round.
// Ports: x      - state after round r (x_(r+1))
//        k_r    - round key for round r
//        x_prev - recovered state before round r (x_r)
module dec_round
    import block_dec_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [KEY_W-1:0]  k_r,
    output logic [DATA_W-1:0] x_prev
);

    logic [DATA_W-1:0] diff;

    // Undo the key add, then the left rotate, then the key XOR.
    always_comb begin
        diff   = x - {{(DATA_W-KEY_W){1'b0}}, k_r};
        x_prev = ((diff >> ROT_AMT) | (diff << (DATA_W - ROT_AMT))) ^ {4{k_r}};
    end

endmodule

// File: rtl/block_dec.sv
// block_dec: iterative decryptor, one inverse round per clock.
// Ports: CLK, RST_N (async active-low), bus (block_dec_if.slave:
//        D_IN/K_IN/IN_VALID/IN_READY in, D_OUT/OUT_VALID/OUT_READY out),
//        BLK_CNT (16-bit handshake counter, only with BLOCK_DEC_COUNT_EN).
// Parameter ROUNDS: number of cipher rounds, 1..8.
module block_dec
    import block_dec_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
`ifdef BLOCK_DEC_COUNT_EN
    output logic [BLK_CNT_W-1:0] BLK_CNT,
`endif
    block_dec_if.slave           bus
);

    state_e            state_q, state_d;
    blk_t              blk_q, blk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [KEY_W-1:0]  k_r;
    logic [DATA_W-1:0] x_prev;

    assign k_r = round_key(blk_q.key, cnt_q);

    dec_round u_dec_round (
        .x      (blk_q.data),
        .k_r    (k_r),
        .x_prev (x_prev)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, datapath and registered handshake flags.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.IN_VALID) begin
                    blk_d.data = bus.D_IN;
                    blk_d.key  = bus.K_IN;
                    cnt_d      = CNT_W'(ROUNDS - 1);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d.data = x_prev;
                if (cnt_q == '0) begin
                    dout_d  = x_prev;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flags follow the next state so they are pure flops of state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.D_OUT     = dout_q;

`ifdef BLOCK_DEC_COUNT_EN
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    // Saturating count of completed output handshakes.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if ((state_q == ST_DONE) && bus.OUT_READY && (blk_cnt_q != '1)) begin
            blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign BLK_CNT = blk_cnt_q;
`endif

endmodule

// File: tb/tb_block_dec.sv
// Directed self-checking bench for block_dec (ROUNDS = 4).
module tb_block_dec;
    import block_dec_pkg::*;

    localparam int unsigned ROUNDS = 4;

    logic CLK;
    logic RST_N;
    int   errors;
    int   checks;

`ifdef BLOCK_DEC_COUNT_EN
    logic [15:0] BLK_CNT;
`endif

    block_dec_if bus ();

    block_dec #(.ROUNDS(ROUNDS)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
`ifdef BLOCK_DEC_COUNT_EN
        .BLK_CNT (BLK_CNT),
`endif
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference encryptor, written forward from the round definition.
    function automatic logic [31:0] enc(input logic [31:0] p, input logic [7:0] k);
        logic [31:0] x;
        logic [31:0] t;
        logic [7:0]  kr;
        x = p;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            kr = 8'((k << r) | (k >> (8 - r)));
            t  = x ^ {4{kr}};
            t  = (t << 3) | (t >> 29);
            x  = t + {24'h0, kr};
        end
        return x;
    endfunction

    task automatic test_reset();
        RST_N        = 1'b0;
        bus.D_IN     = '0;
        bus.K_IN     = '0;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.IN_READY);
        end
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.OUT_VALID);
        end
        checks++;
        if (bus.D_OUT !== 32'h0) begin
            errors++; $display("FAIL reset_d_out got=%h exp=00000000", bus.D_OUT);
        end
        RST_N = 1'b1;
    endtask

    // First edge after reset release accepts; output appears after 4 more edges.
    task automatic test_latency();
        bus.D_IN     = 32'h00001000;
        bus.K_IN     = 8'h00;
        bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL lat_accept_first_edge in_ready=%b exp=0", bus.IN_READY);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                errors++; $display("FAIL lat_early_valid cycle=%0d got=%b exp=0", i, bus.OUT_VALID);
            end
        end
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL lat_valid_at_4 got=%b exp=1", bus.OUT_VALID);
        end
        checks++;
        if (bus.D_OUT !== 32'h00000001) begin
            errors++; $display("FAIL lat_d_out got=%h exp=00000001", bus.D_OUT);
        end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL lat_release in_ready=%b out_valid=%b exp=1/0",
                               bus.IN_READY, bus.OUT_VALID);
        end
    endtask

    task automatic test_zero_ready();
        bus.D_IN      = 32'h0;
        bus.K_IN      = 8'h0;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        tick();
        bus.IN_VALID  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (bus.IN_READY !== 1'b0) begin
                errors++; $display("FAIL zero_in_ready cycle=%0d got=%b exp=0", i, bus.IN_READY);
            end
            if (i == 5) begin
                checks++;
                if (bus.OUT_VALID !== 1'b1 || bus.D_OUT !== 32'h0) begin
                    errors++; $display("FAIL zero_out valid=%b d_out=%h exp=1/00000000",
                                       bus.OUT_VALID, bus.D_OUT);
                end
            end
            tick();
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL zero_ready_back got=%b exp=1", bus.IN_READY);
        end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pt [11];
        logic [31:0] ct [11];
        logic [7:0]  ky [11];
        int in_idx;
        int out_idx;
        int cyc;
        logic acc;
        for (int i = 0; i < 11; i++) begin
            pt[i] = 32'(i + 1);
            ky[i] = 8'(i + 1);
            ct[i] = enc(pt[i], ky[i]);
        end
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        bus.OUT_READY = 1'b1;
        while (out_idx < 11 && cyc < 200) begin
            if (in_idx < 11) begin
                bus.IN_VALID = 1'b1;
                bus.D_IN     = ct[in_idx];
                bus.K_IN     = ky[in_idx];
            end else begin
                bus.IN_VALID = 1'b0;
            end
            acc = bus.IN_READY && bus.IN_VALID;
            if (bus.OUT_VALID) begin
                checks++;
                if (bus.D_OUT !== pt[out_idx]) begin
                    errors++; $display("FAIL b2b_d_out idx=%0d got=%h exp=%h",
                                       out_idx, bus.D_OUT, pt[out_idx]);
                end
                out_idx++;
            end
            tick();
            if (acc) in_idx++;
            cyc++;
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (out_idx != 11) begin
            errors++; $display("FAIL b2b_timeout got=%0d exp=11 blocks", out_idx);
        end
        // 11 blocks at one per 6 cycles, first output handshake at cycle 5.
        checks++;
        if (cyc != 6 * 10 + 6) begin
            errors++; $display("FAIL b2b_throughput cycles=%0d exp=66", cyc);
        end
        tick();
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        bus.OUT_READY = 1'b0;
        bus.D_IN      = enc(32'hDEADBEEF, 8'h5A);
        bus.K_IN      = 8'h5A;
        bus.IN_VALID  = 1'b1;
        tick();
        n = 0;
        while (!bus.OUT_VALID && n < 20) begin
            bus.D_IN = ~bus.D_IN;
            tick();
            n++;
        end
        checks++;
        if (!bus.OUT_VALID) begin
            errors++; $display("FAIL bp_timeout out_valid=%b exp=1", bus.OUT_VALID);
        end
        for (int i = 0; i < 10; i++) begin
            bus.D_IN = 32'(i) * 32'h01010101;
            bus.K_IN = 8'(i * 7);
            bus.IN_VALID = 1'b1;
            tick();
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.D_OUT !== 32'hDEADBEEF || bus.IN_READY !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle=%0d valid=%b d_out=%h in_ready=%b exp=1/deadbeef/0",
                                   i, bus.OUT_VALID, bus.D_OUT, bus.IN_READY);
            end
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL bp_release valid=%b in_ready=%b exp=0/1",
                               bus.OUT_VALID, bus.IN_READY);
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        bus.OUT_READY = 1'b0;
        bus.D_IN      = enc(32'hCAFEF00D, 8'h3C);
        bus.K_IN      = 8'h3C;
        bus.IN_VALID  = 1'b1;
        tick();
        bus.IN_VALID  = 1'b0;
        tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.D_OUT !== 32'h0 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL rst_run_async valid=%b d_out=%h in_ready=%b exp=0/00000000/1",
                               bus.OUT_VALID, bus.D_OUT, bus.IN_READY);
        end
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                errors++; $display("FAIL rst_run_ghost cycle=%0d valid=%b exp=0", i, bus.OUT_VALID);
            end
        end
        bus.D_IN     = enc(32'h12345678, 8'hC3);
        bus.K_IN     = 8'hC3;
        bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        n = 0;
        while (!bus.OUT_VALID && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.D_OUT !== 32'h12345678) begin
            errors++; $display("FAIL rst_run_next valid=%b d_out=%h exp=1/12345678",
                               bus.OUT_VALID, bus.D_OUT);
        end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
    endtask

`ifdef BLOCK_DEC_COUNT_EN
    task automatic run_block(input logic [31:0] p, input logic [7:0] k, output bit ok);
        int n;
        bus.D_IN      = enc(p, k);
        bus.K_IN      = k;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        tick();
        bus.IN_VALID  = 1'b0;
        n = 0;
        while (!bus.OUT_VALID && n < 20) begin
            tick();
            n++;
        end
        ok = bus.OUT_VALID;
        tick();
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_count();
        bit ok;
        RST_N = 1'b0;
        tick();
        checks++;
        if (BLK_CNT !== 16'h0) begin
            errors++; $display("FAIL cnt_reset got=%h exp=0000", BLK_CNT);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_block(32'(i + 100), 8'(i + 9), ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL cnt_block_timeout idx=%0d", i);
            end
        end
        checks++;
        if (BLK_CNT !== 16'd3) begin
            errors++; $display("FAIL cnt_three got=%h exp=0003", BLK_CNT);
        end
        force dut.blk_cnt_q = 16'hFFFF;
        tick();
        release dut.blk_cnt_q;
        run_block(32'h0BADBEEF, 8'h11, ok);
        checks++;
        if (BLK_CNT !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_saturate got=%h exp=ffff", BLK_CNT);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_zero_ready();
        test_back_to_back();
        test_backpressure();
        test_reset_in_run();
`ifdef BLOCK_DEC_COUNT_EN
        test_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
